// File: rtl/spi_slave_in_if.sv
// spi_slave_in_if: bus bundle for the SPI slave receiver.
//   sck, cs, mosi              : serial link driven from off-chip (asynchronous)
//   out_buf, valid, frame_err,
//   busy                       : parallel word output and status toward consumers
// Modport slave is used by the receiver. Modport master is the driving side,
// which is the link source plus the word consumer.
interface spi_slave_in_if #(
  parameter int unsigned BITS = 8
);

  logic            sck;
  logic            cs;
  logic            mosi;
  logic [BITS-1:0] out_buf;
  logic            valid;
  logic            frame_err;
  logic            busy;

  modport slave (
    input  sck,
    input  cs,
    input  mosi,
    output out_buf,
    output valid,
    output frame_err,
    output busy
  );

  modport master (
    output sck,
    output cs,
    output mosi,
    input  out_buf,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/spi_slave_in.sv
// spi_slave_in: serial-input SPI slave receiver.
// The receiver synchronises an external sck/cs/mosi link into the clk domain
// and deserialises MSB-first words. Each completed word is loaded into out_buf
// and marked with a one-cycle valid pulse.
//   clk            : system clock, rising edge
//   reset          : asynchronous reset, active-low
//   bus.sck/cs/mosi: SPI inputs. sck and mosi idle high. cs is active-low.
//   bus.out_buf    : last completed word
//   bus.valid      : one-cycle pulse when out_buf is updated
//   bus.frame_err  : one-cycle pulse when cs deasserts in the middle of a word
//   bus.busy       : registered indication that the receiver is inside a frame
module spi_slave_in #(
  parameter int unsigned BITS        = 8,
  parameter bit          INVERT      = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_slave_in_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);

  // Reject parameter values the logic cannot support.
  if (BITS < 2) begin : g_bits_chk
    $error("spi_slave_in: BITS must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("spi_slave_in: SYNC_STAGES must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchroniser chains. Stage 0 captures the pin; the last stage is the one used.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic rise_c;
  logic bit_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]  sr_q, sr_d;
  logic [BITS-1:0]  out_q, out_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic [CNT_W-1:0] n_c;

  // Input synchronisers. They reset to the idle-high level so that leaving
  // reset cannot look like an sck rise or a cs fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sck_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise_c = sck_s & ~sck_d;
  assign bit_c  = mosi_s ^ INVERT;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q == RECV);
    end
  end

  // Next-state logic. The shift is applied before the word-complete test, so an
  // sck rise in the same cycle that cs goes high still completes the word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    n_c     = cnt_q;

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end

      RECV: begin
        if (rise_c) begin
          sr_d = {sr_q[BITS-2:0], bit_c};
          n_c  = cnt_q + CNT_W'(1);
        end

        if (n_c == CNT_FULL) begin
          out_d   = sr_d;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = n_c;
        end

        // Deselect ends the frame. A partial word is dropped and flagged.
        if (cs_s) begin
          state_d = IDLE;
          if ((n_c != '0) && (n_c != CNT_FULL)) begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_buf   = out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule
